decode_pipe_stage: RTL and testbench
====================================

DECODE_PIPE_STAGE -- requirements
Module: Decode_Pipe_Stage

Interface
REQ-001 Parameter XLEN, default 16, register/operand data width; legal values 16..32.
REQ-002 Parameter BYPASS, default 1, 1 = same-cycle write-to-read bypass in the register file.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_valid  in  1  fetch presents a valid instruction.
REQ-006 pc_in  in  16  PC of fetched instruction.
REQ-007 ir_in  in  16  fetched instruction word.
REQ-008 flush  in  1  EX redirect; kill IF/ID and ID/EX contents.
REQ-009 wb_we  in  1  writeback enable.
REQ-010 wb_addr  in  3  writeback register index.
REQ-011 wb_data  in  XLEN  writeback data.
REQ-012 stall  out  1  hold fetch (load-use hazard).
REQ-013 jump  out  1  one-cycle redirect for JAL in ID.
REQ-014 new_pc  out  16  JAL target.
REQ-015 ex_valid, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_illegal  out  1 each  registered ID/EX controls.
REQ-016 ex_ALUOp  out  3; ex_rd  out  3; ex_pc  out  16; ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  registered ID/EX fields.

Function
REQ-017 Fields: opcode=ir[15:12], rd=ir[11:9], rs1=ir[8:6], rs2=ir[5:3], funct=ir[2:0], imm6=ir[5:0], imm9=ir[8:0].
REQ-018 Decode: 0 R-type (RegWrite, ALUOp=funct); 1 ADDI (RegWrite, ALUSrc, ALUOp=0); 2 LW (RegWrite, ALUSrc, MemRead); 3 SW (ALUSrc, MemWrite, rd read as store data via rs2 port); 4 JAL (RegWrite, jump); other opcodes: all controls 0, ex_illegal=1.
REQ-019 ex_imm = imm6 sign-extended to XLEN; for JAL ex_imm = pc+2 zero-extended (link value).
REQ-020 new_pc = pc + (sign-extend(imm9) << 1), modulo 2^16.
REQ-021 Register file: 8 x XLEN, r0 reads zero, writes to r0 ignored; write on clk edge when wb_we.
REQ-022 BYPASS=1: read index == wb_addr (non-zero) with wb_we high returns wb_data same cycle; BYPASS=0: returns old value.
REQ-023 IF/ID register: captures pc_in/ir_in/if_valid each edge unless stall=1 (hold); loads invalid on flush or when jump=1.
REQ-024 Load-use: stall=1 combinationally when IF/ID valid, ex_valid, ex_MemRead, ex_rd!=0, and ex_rd equals rs1 or the second read index of the ID instruction.
REQ-025 During stall, ID/EX loads a bubble (ex_valid=0, all controls 0); stall lasts exactly one cycle per hazard.
REQ-026 jump asserts only when IF/ID valid, opcode=4, stall=0, flush=0; ID/EX receives the JAL normally.
REQ-027 flush has priority over stall and jump: next edge IF/ID and ID/EX both invalid; stall, jump forced 0 that cycle.
REQ-028 Controls of an invalid ID/EX entry are all 0; latency IF/ID capture to ex_* outputs = 1 cycle after ID.

Reset
REQ-029 reset low clears asynchronously: IF/ID invalid, all ex_* outputs 0, register file all 0; stall, jump, new_pc combinationally 0 while IF/ID invalid.
REQ-030 reset release mid-stream: first instruction decoded is the one captured on the first edge after release.

Verification
REQ-031 wb_we=1,wb_addr=3,wb_data=0x1234; then ADDI rd=1,rs1=3,imm6=0x3F -> next cycle ex_rs1_val=0x1234, ex_imm=0xFFFF, ex_ALUSrc=1, ex_RegWrite=1.
REQ-032 LW rd=2 followed by R-type rs1=2 -> stall=1 one cycle, one bubble (ex_valid=0), R-type reaches EX next cycle with ex_ALUOp=funct.
REQ-033 JAL at pc=0x0010, imm9=0x1FE -> jump=1, new_pc=0x000C, following IF/ID entry killed, ex_imm=0x0012.
REQ-034 flush asserted in same cycle as a load-use stall -> stall=0, ex_valid=0 next two decoded slots until new valid fetch.
REQ-035 BYPASS=1 read of r5 during write r5=0xBEEF -> ex_rs1_val=0xBEEF; BYPASS=0 -> previous value; write to r0 -> r0 still reads 0.
REQ-036 Opcode 0xF -> ex_illegal=1, all other controls 0; reset asserted mid-pipeline -> all ex_* 0 immediately, XLEN=32 rerun passes.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Instruction-decode stage of a small 16-bit-instruction pipeline.
// It contains the IF/ID pipeline register, an 8-entry register file with an
// optional write-to-read bypass, the instruction decoder, load-use hazard
// detection, JAL redirect generation and the ID/EX pipeline register.
//
// Parameters
//   XLEN    register / operand width (16..32)
//   BYPASS  1 = a register read sees a writeback to the same index in the
//           same cycle; 0 = the read returns the previously stored value
//
// Ports
//   clk, reset          clock (rising edge) / asynchronous active-low reset
//   if_valid, pc_in,    fetched instruction and its PC
//   ir_in
//   flush               EX redirect; kills IF/ID and ID/EX contents
//   wb_we, wb_addr,     register-file writeback port
//   wb_data
//   stall               hold fetch for one cycle (load-use hazard)
//   jump, new_pc        one-cycle redirect for a JAL sitting in ID
//   ex_*                registered ID/EX controls and operand fields
// ---------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int XLEN   = 16,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [15:0]     pc_in,
    input  logic [15:0]     ir_in,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [2:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            jump,
    output logic [15:0]     new_pc,
    output logic            ex_valid,
    output logic            ex_RegWrite,
    output logic            ex_ALUSrc,
    output logic            ex_MemWrite,
    output logic            ex_MemRead,
    output logic            ex_illegal,
    output logic [2:0]      ex_ALUOp,
    output logic [2:0]      ex_rd,
    output logic [15:0]     ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm
);

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_JAL  = 4'h4;

    // IF/ID register
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_ir;

    // Register file (kept in flops: it must clear on asynchronous reset)
    logic [XLEN-1:0] rf_reg [8];

    // Instruction fields
    logic [3:0] opcode;
    logic [2:0] rd_f;
    logic [2:0] rs1_f;
    logic [2:0] rs2_f;
    logic [2:0] funct_f;
    logic [2:0] rs2_idx;

    // Decoded controls
    logic            dec_regwrite;
    logic            dec_alusrc;
    logic            dec_memwrite;
    logic            dec_memread;
    logic            dec_illegal;
    logic            dec_jal;
    logic [2:0]      dec_aluop;
    logic [XLEN-1:0] dec_imm;
    logic [15:0]     jal_target;
    logic [15:0]     link_pc;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;

    assign opcode  = ifid_ir[15:12];
    assign rd_f    = ifid_ir[11:9];
    assign rs1_f   = ifid_ir[8:6];
    assign rs2_f   = ifid_ir[5:3];
    assign funct_f = ifid_ir[2:0];

    // Stores read their data register (rd field) through the second port.
    assign rs2_idx = (opcode == OP_SW) ? rd_f : rs2_f;

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_we && wb_addr != 3'd0) begin
            rf_reg[wb_addr] <= wb_data;
        end
    end

    // r0 is hard-wired to zero; optional same-cycle forwarding of writeback.
    function automatic logic [XLEN-1:0] read_port(
        input logic [2:0]      idx,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [2:0]      waddr,
        input logic [XLEN-1:0] wdata
    );
        if (idx == 3'd0) begin
            return '0;
        end
        if (BYPASS != 0 && we && waddr == idx) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rs1_val = read_port(rs1_f,   rf_reg[rs1_f],   wb_we, wb_addr, wb_data);
    assign rs2_val = read_port(rs2_idx, rf_reg[rs2_idx], wb_we, wb_addr, wb_data);

    // ---------------------------------------------------------------------
    // Decoder
    // ---------------------------------------------------------------------
    assign link_pc    = ifid_pc + 16'd2;
    assign jal_target = ifid_pc + {{6{ifid_ir[8]}}, ifid_ir[8:0], 1'b0};

    always_comb begin
        dec_regwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_illegal  = 1'b0;
        dec_jal      = 1'b0;
        dec_aluop    = 3'd0;
        dec_imm      = XLEN'($signed(ifid_ir[5:0]));
        case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_aluop    = funct_f;
            end
            OP_ADDI: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_LW: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_memread  = 1'b1;
            end
            OP_SW: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_JAL: begin
                dec_regwrite = 1'b1;
                dec_jal      = 1'b1;
                // The immediate slot carries the link value for JAL.
                dec_imm      = XLEN'(link_pc);
            end
            default: begin
                dec_illegal  = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Hazard / redirect. flush overrides both stall and jump.
    // ---------------------------------------------------------------------
    assign hazard = ifid_valid && ex_valid && ex_MemRead && (ex_rd != 3'd0) &&
                    ((ex_rd == rs1_f) || (ex_rd == rs2_idx));
    assign stall  = hazard && !flush;
    assign jump   = ifid_valid && dec_jal && !stall && !flush;
    assign new_pc = ifid_valid ? jal_target : 16'd0;

    // ---------------------------------------------------------------------
    // IF/ID register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 16'd0;
            ifid_ir    <= 16'd0;
        end else if (flush || jump) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_valid <= if_valid;
            ifid_pc    <= pc_in;
            ifid_ir    <= ir_in;
        end
    end

    // ---------------------------------------------------------------------
    // ID/EX register: flush, stall and an empty ID all insert a bubble.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_ALUOp    <= 3'd0;
            ex_rd       <= 3'd0;
            ex_pc       <= 16'd0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
        end else if (flush || stall || !ifid_valid) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_ALUOp    <= 3'd0;
            ex_rd       <= 3'd0;
            ex_pc       <= 16'd0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_RegWrite <= dec_regwrite;
            ex_ALUSrc   <= dec_alusrc;
            ex_MemWrite <= dec_memwrite;
            ex_MemRead  <= dec_memread;
            ex_illegal  <= dec_illegal;
            ex_ALUOp    <= dec_aluop;
            ex_rd       <= rd_f;
            ex_pc       <= ifid_pc;
            ex_rs1_val  <= rs1_val;
            ex_rs2_val  <= rs2_val;
            ex_imm      <= dec_imm;
        end
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Drives two copies of decode_pipe_stage with identical stimulus:
//   dut_a : XLEN=16, BYPASS=1
//   dut_b : XLEN=32, BYPASS=0
// A behavioural model of the decode stage predicts stall/jump/new_pc each
// cycle and the ID/EX contents after each edge. Directed scenarios come
// first, then randomized traffic with a mid-stream reset.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [15:0] pc_in;
    logic [15:0] ir_in;
    logic        flush;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;

    logic        stall_a, jump_a, stall_b, jump_b;
    logic [15:0] new_pc_a, new_pc_b;
    logic        ex_valid_a, ex_RegWrite_a, ex_ALUSrc_a, ex_MemWrite_a, ex_MemRead_a, ex_illegal_a;
    logic        ex_valid_b, ex_RegWrite_b, ex_ALUSrc_b, ex_MemWrite_b, ex_MemRead_b, ex_illegal_b;
    logic [2:0]  ex_ALUOp_a, ex_rd_a, ex_ALUOp_b, ex_rd_b;
    logic [15:0] ex_pc_a, ex_pc_b;
    logic [15:0] ex_rs1_val_a, ex_rs2_val_a, ex_imm_a;
    logic [31:0] ex_rs1_val_b, ex_rs2_val_b, ex_imm_b;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(16), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .if_valid(if_valid), .pc_in(pc_in), .ir_in(ir_in),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data[15:0]),
        .stall(stall_a), .jump(jump_a), .new_pc(new_pc_a),
        .ex_valid(ex_valid_a), .ex_RegWrite(ex_RegWrite_a), .ex_ALUSrc(ex_ALUSrc_a),
        .ex_MemWrite(ex_MemWrite_a), .ex_MemRead(ex_MemRead_a), .ex_illegal(ex_illegal_a),
        .ex_ALUOp(ex_ALUOp_a), .ex_rd(ex_rd_a), .ex_pc(ex_pc_a),
        .ex_rs1_val(ex_rs1_val_a), .ex_rs2_val(ex_rs2_val_a), .ex_imm(ex_imm_a)
    );

    decode_pipe_stage #(.XLEN(32), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .if_valid(if_valid), .pc_in(pc_in), .ir_in(ir_in),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall_b), .jump(jump_b), .new_pc(new_pc_b),
        .ex_valid(ex_valid_b), .ex_RegWrite(ex_RegWrite_b), .ex_ALUSrc(ex_ALUSrc_b),
        .ex_MemWrite(ex_MemWrite_b), .ex_MemRead(ex_MemRead_b), .ex_illegal(ex_illegal_b),
        .ex_ALUOp(ex_ALUOp_b), .ex_rd(ex_rd_b), .ex_pc(ex_pc_b),
        .ex_rs1_val(ex_rs1_val_b), .ex_rs2_val(ex_rs2_val_b), .ex_imm(ex_imm_b)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit        valid, regwrite, alusrc, memwrite, memread, illegal;
        bit [2:0]  aluop, rd;
        bit [15:0] pc;
        bit [31:0] rs1_a, rs2_a, imm_a, rs1_b, rs2_b, imm_b;
    } ex_t;

    bit        m_ifv;
    bit [15:0] m_ifpc, m_ifir;
    ex_t       m_ex;
    bit [31:0] m_rf [8];
    bit        m_stall, m_jump;
    bit [15:0] m_new_pc;

    int checks = 0;
    int errors = 0;
    logic        obs_stall, obs_jump;
    logic [15:0] obs_new_pc;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        m_ifv  = 0;
        m_ifpc = 0;
        m_ifir = 0;
        m_ex   = '{default: '0};
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
    endfunction

    function automatic bit [2:0] second_idx(input bit [15:0] ir);
        return (ir[15:12] == 4'd3) ? ir[11:9] : ir[5:3];
    endfunction

    // Combinational outputs of the stage given the current model state.
    function automatic void model_comb();
        bit [2:0] rs1, rs2;
        int s9;
        rs1 = m_ifir[8:6];
        rs2 = second_idx(m_ifir);
        m_stall = !flush && m_ifv && m_ex.valid && m_ex.memread && m_ex.rd != 0 &&
                  (m_ex.rd == rs1 || m_ex.rd == rs2);
        m_jump  = !flush && m_ifv && m_ifir[15:12] == 4'd4 && !m_stall;
        s9 = int'(m_ifir[8:0]);
        if (s9 >= 256) s9 -= 512;
        m_new_pc = m_ifv ? 16'((int'(m_ifpc) + 2 * s9) & 32'hFFFF) : 16'd0;
    endfunction

    function automatic bit [31:0] read_a(input bit [2:0] i);
        if (i == 0) return 0;
        if (wb_we && wb_addr == i) return wb_data & 32'hFFFF;
        return m_rf[i] & 32'hFFFF;
    endfunction

    function automatic bit [31:0] read_b(input bit [2:0] i);
        if (i == 0) return 0;
        return m_rf[i];
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_step();
        ex_t      nx;
        bit [3:0] op;
        bit [2:0] rs1, rs2;
        int       s6;
        nx  = '{default: '0};
        op  = m_ifir[15:12];
        rs1 = m_ifir[8:6];
        rs2 = second_idx(m_ifir);
        s6  = int'(m_ifir[5:0]);
        if (s6 >= 32) s6 -= 64;
        if (m_ifv && !flush && !m_stall) begin
            nx.valid = 1;
            nx.rd    = m_ifir[11:9];
            nx.pc    = m_ifpc;
            nx.rs1_a = read_a(rs1);
            nx.rs2_a = read_a(rs2);
            nx.rs1_b = read_b(rs1);
            nx.rs2_b = read_b(rs2);
            nx.imm_b = 32'(s6);
            nx.imm_a = nx.imm_b & 32'hFFFF;
            case (op)
                4'd0: begin nx.regwrite = 1; nx.aluop = m_ifir[2:0]; end
                4'd1: begin nx.regwrite = 1; nx.alusrc = 1; end
                4'd2: begin nx.regwrite = 1; nx.alusrc = 1; nx.memread = 1; end
                4'd3: begin nx.alusrc = 1; nx.memwrite = 1; end
                4'd4: begin
                    nx.regwrite = 1;
                    nx.imm_b = (int'(m_ifpc) + 2) & 32'hFFFF;
                    nx.imm_a = nx.imm_b;
                end
                default: nx.illegal = 1;
            endcase
        end
        if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
        if (flush || m_jump) begin
            m_ifv = 0;
        end else if (!m_stall) begin
            m_ifv  = if_valid;
            m_ifpc = pc_in;
            m_ifir = ir_in;
        end
        m_ex = nx;
    endfunction

    task automatic check_comb();
        model_comb();
        chk("stall_a",  stall_a,  m_stall);
        chk("stall_b",  stall_b,  m_stall);
        chk("jump_a",   jump_a,   m_jump);
        chk("jump_b",   jump_b,   m_jump);
        chk("new_pc_a", new_pc_a, m_new_pc);
        chk("new_pc_b", new_pc_b, m_new_pc);
    endtask

    task automatic check_ex();
        chk("ex_valid_a",    ex_valid_a,    m_ex.valid);
        chk("ex_RegWrite_a", ex_RegWrite_a, m_ex.regwrite);
        chk("ex_ALUSrc_a",   ex_ALUSrc_a,   m_ex.alusrc);
        chk("ex_MemWrite_a", ex_MemWrite_a, m_ex.memwrite);
        chk("ex_MemRead_a",  ex_MemRead_a,  m_ex.memread);
        chk("ex_illegal_a",  ex_illegal_a,  m_ex.illegal);
        chk("ex_ALUOp_a",    ex_ALUOp_a,    m_ex.aluop);
        chk("ex_rd_a",       ex_rd_a,       m_ex.rd);
        chk("ex_pc_a",       ex_pc_a,       m_ex.pc);
        chk("ex_rs1_val_a",  ex_rs1_val_a,  m_ex.rs1_a);
        chk("ex_rs2_val_a",  ex_rs2_val_a,  m_ex.rs2_a);
        chk("ex_imm_a",      ex_imm_a,      m_ex.imm_a);
        chk("ex_valid_b",    ex_valid_b,    m_ex.valid);
        chk("ex_RegWrite_b", ex_RegWrite_b, m_ex.regwrite);
        chk("ex_ALUSrc_b",   ex_ALUSrc_b,   m_ex.alusrc);
        chk("ex_MemWrite_b", ex_MemWrite_b, m_ex.memwrite);
        chk("ex_MemRead_b",  ex_MemRead_b,  m_ex.memread);
        chk("ex_illegal_b",  ex_illegal_b,  m_ex.illegal);
        chk("ex_ALUOp_b",    ex_ALUOp_b,    m_ex.aluop);
        chk("ex_rd_b",       ex_rd_b,       m_ex.rd);
        chk("ex_pc_b",       ex_pc_b,       m_ex.pc);
        chk("ex_rs1_val_b",  ex_rs1_val_b,  m_ex.rs1_b);
        chk("ex_rs2_val_b",  ex_rs2_val_b,  m_ex.rs2_b);
        chk("ex_imm_b",      ex_imm_b,      m_ex.imm_b);
    endtask

    // Present inputs, check comb outputs at the falling edge, then check
    // the ID/EX register just after the rising edge.
    task automatic step(input bit v, input bit [15:0] pc, input bit [15:0] ir, input bit fl,
                        input bit we, input bit [2:0] wa, input bit [31:0] wd);
        if_valid = v;
        pc_in    = pc;
        ir_in    = ir;
        flush    = fl;
        wb_we    = we;
        wb_addr  = wa;
        wb_data  = wd;
        @(negedge clk);
        obs_stall  = stall_a;
        obs_jump   = jump_a;
        obs_new_pc = new_pc_a;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_ex();
        $display("t=%0t v=%b pc=%h ir=%h flush=%b wb=%b/%0d/%h stall=%b jump=%b new_pc=%h ex_valid=%b ex_pc=%h",
                 $time, v, pc, ir, fl, we, wa, wd, obs_stall, obs_jump, obs_new_pc, ex_valid_a, ex_pc_a);
    endtask

    task automatic idle();
        step(0, 16'h0, 16'h0, 0, 0, 3'd0, 32'h0);
    endtask

    task automatic mid_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_comb();
        check_ex();
        $display("t=%0t reset asserted mid-pipeline", $time);
        reset = 1'b1;
    endtask

    function automatic bit [15:0] rand_instr();
        bit [2:0] rd, rs1, rs2;
        int sel;
        rd  = 3'($urandom_range(0, 3));
        rs1 = 3'($urandom_range(0, 3));
        rs2 = 3'($urandom_range(0, 3));
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 8: return {4'h0, rd, rs1, rs2, 3'($urandom_range(0, 7))};
            2:       return {4'h1, rd, rs1, 6'($urandom_range(0, 63))};
            3, 4:    return {4'h2, rd, rs1, 6'($urandom_range(0, 63))};
            5:       return {4'h3, rd, rs1, 6'($urandom_range(0, 63))};
            6:       return {4'h4, rd, 9'($urandom_range(0, 511))};
            default: return {4'($urandom_range(5, 15)), 12'($urandom_range(0, 4095))};
        endcase
    endfunction

    task automatic random_run(input int n);
        bit [15:0] cur_pc, cur_ir;
        bit        cur_v;
        cur_pc = 16'h0100;
        cur_ir = rand_instr();
        cur_v  = 1;
        for (int k = 0; k < n; k++) begin
            step(cur_v, cur_pc, cur_ir, ($urandom_range(0, 11) == 0),
                 bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            // Fetch model: hold on stall, follow a JAL redirect, else advance.
            if (!m_stall) begin
                cur_pc = m_jump ? m_new_pc : cur_pc + 16'd2;
                cur_ir = rand_instr();
                cur_v  = ($urandom_range(0, 7) != 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        if_valid = 0;
        pc_in    = 0;
        ir_in    = 0;
        flush    = 0;
        wb_we    = 0;
        wb_addr  = 0;
        wb_data  = 0;
        model_reset();
        #12;
        check_comb();
        check_ex();
        reset = 1'b1;

        // Writeback r3, then ADDI r1 = r3 + (-1)
        step(0, 16'h0, 16'h0, 0, 1, 3'd3, 32'h1234);
        step(1, 16'h0000, {4'h1, 3'd1, 3'd3, 6'h3F}, 0, 0, 3'd0, 32'h0);
        idle();
        chk("addi_rs1",      ex_rs1_val_a,  32'h1234);
        chk("addi_imm16",    ex_imm_a,      32'hFFFF);
        chk("addi_imm32",    ex_imm_b,      32'hFFFF_FFFF);
        chk("addi_alusrc",   ex_ALUSrc_a,   1);
        chk("addi_regwrite", ex_RegWrite_a, 1);

        // Load-use: LW r2 then R-type reading r2
        step(1, 16'h0020, {4'h2, 3'd2, 3'd0, 6'd4}, 0, 0, 3'd0, 32'h0);
        step(1, 16'h0022, {4'h0, 3'd4, 3'd2, 3'd1, 3'd5}, 0, 0, 3'd0, 32'h0);
        step(1, 16'h0024, 16'h0000, 0, 0, 3'd0, 32'h0);
        chk("lu_stall",  obs_stall,  1);
        chk("lu_bubble", ex_valid_a, 0);
        idle();
        chk("lu_stall_gone", obs_stall,  0);
        chk("lu_rtype_valid", ex_valid_a, 1);
        chk("lu_rtype_aluop", ex_ALUOp_a, 5);

        // JAL at 0x0010 with imm9 = -2
        step(1, 16'h0010, {4'h4, 3'd7, 9'h1FE}, 0, 0, 3'd0, 32'h0);
        step(1, 16'h0012, {4'h1, 3'd1, 3'd1, 6'd1}, 0, 0, 3'd0, 32'h0);
        chk("jal_jump",   obs_jump,   1);
        chk("jal_new_pc", obs_new_pc, 16'h000C);
        chk("jal_link",   ex_imm_a,   16'h0012);
        idle();
        chk("jal_killed", ex_valid_a, 0);

        // flush in the same cycle as a load-use hazard
        step(1, 16'h0030, {4'h2, 3'd3, 3'd0, 6'd0}, 0, 0, 3'd0, 32'h0);
        step(1, 16'h0032, {4'h0, 3'd1, 3'd0, 3'd3, 3'd0}, 0, 0, 3'd0, 32'h0);
        step(1, 16'h0032, {4'h0, 3'd1, 3'd0, 3'd3, 3'd0}, 1, 0, 3'd0, 32'h0);
        chk("flush_stall",  obs_stall,  0);
        chk("flush_slot1",  ex_valid_a, 0);
        idle();
        chk("flush_slot2",  ex_valid_a, 0);

        // Bypass vs. no bypass on r5; writes to r0 are dropped
        step(0, 16'h0, 16'h0, 0, 1, 3'd5, 32'h1111);
        step(1, 16'h0040, {4'h1, 3'd1, 3'd5, 6'd0}, 0, 0, 3'd0, 32'h0);
        step(0, 16'h0, 16'h0, 0, 1, 3'd5, 32'hBEEF);
        chk("bypass_on",  ex_rs1_val_a, 32'hBEEF);
        chk("bypass_off", ex_rs1_val_b, 32'h1111);
        step(1, 16'h0042, {4'h1, 3'd1, 3'd0, 6'd0}, 0, 1, 3'd0, 32'h5555);
        step(0, 16'h0, 16'h0, 0, 1, 3'd0, 32'h7777);
        chk("r0_zero_a", ex_rs1_val_a, 0);
        chk("r0_zero_b", ex_rs1_val_b, 0);

        // Illegal opcode
        step(1, 16'h0050, 16'hF123, 0, 0, 3'd0, 32'h0);
        idle();
        chk("illegal_flag", ex_illegal_a,  1);
        chk("illegal_rw",   ex_RegWrite_a, 0);

        random_run(250);
        mid_reset();
        random_run(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
